// File: rtl/systolic_collector.sv
// Collects skewed per-row result bursts of an NxN systolic array into row FIFOs
// and serialises them as (row, col, data) words. Optional macro: SYSTOLIC_COLLECTOR_RELU_EN.
module systolic_collector #(
    parameter int unsigned D_W        = 8,
    parameter int unsigned N          = 3,
    parameter int unsigned M          = 6,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*D_W-1:0]     m2 [N-1:0],
    input  logic [N-1:0]         valid_m2,
    output logic [2*D_W-1:0]     out_data,
    output logic [$clog2(M)-1:0] out_row,
    output logic [$clog2(M)-1:0] out_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 tile_done,
    output logic                 matrix_done,
    output logic                 overflow
);

    localparam int unsigned DW2  = 2 * D_W;
    localparam int unsigned RW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TN   = M / N;
    localparam int unsigned TW   = (TN > 1) ? $clog2(TN) : 1;
    localparam int unsigned CW   = $clog2(M);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [DW2-1:0]  mem_q    [N][FIFO_DEPTH];
    logic [DW2-1:0]  mem_d    [N][FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q [N];
    logic [PW-1:0]   wr_ptr_d [N];
    logic [PW-1:0]   rd_ptr_q [N];
    logic [PW-1:0]   rd_ptr_d [N];
    logic [CNTW-1:0] cnt_q    [N];
    logic [CNTW-1:0] cnt_d    [N];

    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] k_q, k_d;
    logic [TW-1:0] tile_row_q, tile_row_d;
    logic [TW-1:0] tile_col_q, tile_col_d;
    logic          tile_done_q, tile_done_d;
    logic          matrix_done_q, matrix_done_d;
    logic          overflow_q, overflow_d;

    logic [N-1:0]   pop;
    logic [N-1:0]   push_ok;
    logic [DW2-1:0] head;
    logic           hs;

    // Drain side: row r's FIFO head is presented until accepted.
    assign head      = mem_q[r_q][rd_ptr_q[r_q]];
    assign out_valid = (cnt_q[r_q] != '0);
    assign hs        = out_valid && out_ready;
    assign out_row   = CW'(tile_row_q) * CW'(N) + CW'(r_q);
    assign out_col   = CW'(tile_col_q) * CW'(N) + CW'(N - 1) - CW'(k_q);

`ifdef SYSTOLIC_COLLECTOR_RELU_EN
    assign out_data = head[DW2-1] ? '0 : head;
`else
    assign out_data = head;
`endif

    assign tile_done   = tile_done_q;
    assign matrix_done = matrix_done_q;
    assign overflow    = overflow_q;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        r_d           = r_q;
        k_d           = k_q;
        tile_row_d    = tile_row_q;
        tile_col_d    = tile_col_q;
        tile_done_d   = 1'b0;
        matrix_done_d = 1'b0;
        overflow_d    = overflow_q;
        pop           = '0;
        push_ok       = '0;

        // A full FIFO still accepts a push when it is popped in the same cycle.
        for (int i = 0; i < N; i++) begin
            pop[i]     = hs && (RW'(i) == r_q);
            push_ok[i] = valid_m2[i] && ((cnt_q[i] != CNTW'(FIFO_DEPTH)) || pop[i]);
            if (valid_m2[i] && !push_ok[i]) begin
                overflow_d = 1'b1;
            end
            if (push_ok[i]) begin
                mem_d[i][wr_ptr_q[i]] = m2[i];
                wr_ptr_d[i]           = PW'(wr_ptr_q[i] + 1'b1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = PW'(rd_ptr_q[i] + 1'b1);
            end
            cnt_d[i] = cnt_q[i] + CNTW'(push_ok[i]) - CNTW'(pop[i]);
        end

        if (hs) begin
            if (k_q != RW'(N - 1)) begin
                k_d = RW'(k_q + 1'b1);
            end else begin
                k_d = '0;
                if (r_q != RW'(N - 1)) begin
                    r_d = RW'(r_q + 1'b1);
                end else begin
                    r_d         = '0;
                    tile_done_d = 1'b1;
                    if (tile_col_q != TW'(TN - 1)) begin
                        tile_col_d = TW'(tile_col_q + 1'b1);
                    end else begin
                        tile_col_d = '0;
                        if (tile_row_q != TW'(TN - 1)) begin
                            tile_row_d = TW'(tile_row_q + 1'b1);
                        end else begin
                            tile_row_d    = '0;
                            matrix_done_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            r_q           <= '0;
            k_q           <= '0;
            tile_row_q    <= '0;
            tile_col_q    <= '0;
            tile_done_q   <= 1'b0;
            matrix_done_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            r_q           <= r_d;
            k_q           <= k_d;
            tile_row_q    <= tile_row_d;
            tile_col_q    <= tile_col_d;
            tile_done_q   <= tile_done_d;
            matrix_done_q <= matrix_done_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_systolic_collector.sv
// Self-checking bench for systolic_collector: queue-based reference model,
// directed vector tables and randomized traffic.
module tb_systolic_collector;

    localparam int D_W = 8, N = 3, M = 6, DEPTH = 8;
    localparam int T = M / N, NN = N * N, WPM = T * T * NN;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m2 [2:0];
    logic [2:0]  valid_m2;
    logic [15:0] out_data;
    logic [2:0]  out_row, out_col;
    logic        out_valid, out_ready, tile_done, matrix_done, overflow;

    always #5 clk = ~clk;

    systolic_collector #(.D_W(D_W), .N(N), .M(M), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .m2(m2), .valid_m2(valid_m2),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .tile_done(tile_done), .matrix_done(matrix_done), .overflow(overflow)
    );

    typedef struct {
        int          row;
        int          col;
        logic [15:0] data;
    } word_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dexp;
    } relu_vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q [N][$];
    bit          m_ovf, exp_td, exp_md;
    int          w, td_cnt, md_cnt;
    word_t       got [$];

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Compare outputs with the model, advance the model over the next edge.
    task automatic tick();
        int r, tile;
        bit ev, hs;
        word_t wd;
        r    = (w % NN) / N;
        tile = (w / NN) % (T * T);
        ev   = (q[r].size() != 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            chk("out_data", 32'(out_data), 32'(relu(q[r][0])));
            chk("out_row", 32'(out_row), 32'((tile / T) * N + r));
            chk("out_col", 32'(out_col), 32'((tile % T) * N + (N - 1 - (w % N))));
        end
        chk("tile_done", 32'(tile_done), 32'(exp_td));
        chk("matrix_done", 32'(matrix_done), 32'(exp_md));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (tile_done) td_cnt++;
        if (matrix_done) md_cnt++;
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_ovf = 0; w = 0; exp_td = 0; exp_md = 0;
        end else begin
            hs = ev && out_ready;
            exp_td = 0; exp_md = 0;
            if (hs) begin
                wd.row = int'(out_row); wd.col = int'(out_col); wd.data = out_data;
                got.push_back(wd);
                void'(q[r].pop_front());
                if (w % NN == NN - 1) exp_td = 1;
                if (w % WPM == WPM - 1) exp_md = 1;
                w++;
            end
            for (int i = 0; i < N; i++) begin
                if (valid_m2[i]) begin
                    if (q[i].size() < DEPTH) q[i].push_back(m2[i]);
                    else m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_m2 = '0;
        repeat (n) tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        valid_m2 = '0;
        tick();
        rst = 1'b0;
        got.delete();
        td_cnt = 0; md_cnt = 0;
    endtask

    // One skewed tile; row i word j carries base[i]+(N-1-j), or random data.
    task automatic drive_tile(input bit rnd);
        for (int t = 0; t < N + N - 1; t++) begin
            for (int i = 0; i < N; i++) begin
                valid_m2[i] = (t >= i) && (t - i < N);
                m2[i] = valid_m2[i] ? (rnd ? 16'($urandom) : 16'(10 * i + (N - 1 - (t - i)))) : 16'h0;
            end
            tick();
        end
        valid_m2 = '0;
    endtask

    word_t     t1 [9];
    relu_vec_t rv [3];
    int        row0_cnt;

    initial begin
        t1[0] = '{0, 2, 16'd2};  t1[1] = '{0, 1, 16'd1};  t1[2] = '{0, 0, 16'd0};
        t1[3] = '{1, 2, 16'd12}; t1[4] = '{1, 1, 16'd11}; t1[5] = '{1, 0, 16'd10};
        t1[6] = '{2, 2, 16'd22}; t1[7] = '{2, 1, 16'd21}; t1[8] = '{2, 0, 16'd20};
        rv[0] = '{16'hFFF6, relu(16'hFFF6)};
        rv[1] = '{16'h0005, 16'h0005};
        rv[2] = '{16'h8000, relu(16'h8000)};
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
        rv[0].dexp = 16'h0000;
        rv[2].dexp = 16'h0000;
`else
        rv[0].dexp = 16'hFFF6;
        rv[2].dexp = 16'h8000;
`endif

        rst = 1'b1; valid_m2 = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) m2[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ovf = 0; w = 0; exp_td = 0; exp_md = 0; td_cnt = 0; md_cnt = 0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset tile_done", 32'(tile_done), 32'd0);
        chk("reset matrix_done", 32'(matrix_done), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);

        // Single tile, consumer always ready.
        out_ready = 1'b1;
        drive_tile(1'b0);
        idle(15);
        chk("t1 word count", 32'(got.size()), 32'd9);
        for (int e = 0; e < 9 && e < got.size(); e++) begin
            chk("t1 row", 32'(got[e].row), 32'(t1[e].row));
            chk("t1 col", 32'(got[e].col), 32'(t1[e].col));
            chk("t1 data", 32'(got[e].data), 32'(t1[e].data));
        end
        chk("t1 tile_done pulses", 32'(td_cnt), 32'd1);

        // Four tiles covering the full matrix, then wrap to the origin.
        reset_dut();
        out_ready = 1'b1;
        for (int j = 0; j < T * T; j++) begin
            drive_tile(1'b1);
            idle(4);
        end
        idle(20);
        chk("t2 word count", 32'(got.size()), 32'(WPM));
        for (int j = 0; j < T * T && 9 * j < got.size(); j++) begin
            chk("t2 tile row origin", 32'(got[9 * j].row), 32'((j / T) * N));
            chk("t2 tile col origin", 32'(got[9 * j].col), 32'((j % T) * N + N - 1));
        end
        chk("t2 tile_done pulses", 32'(td_cnt), 32'(T * T));
        chk("t2 matrix_done pulses", 32'(md_cnt), 32'd1);
        drive_tile(1'b1);
        idle(10);
        if (got.size() > WPM) begin
            chk("t2 wrap row", 32'(got[WPM].row), 32'd0);
            chk("t2 wrap col", 32'(got[WPM].col), 32'(N - 1));
        end else begin
            chk("t2 wrap word present", 32'(got.size()), 32'(WPM + 1));
        end

        // Consumer stalled while a tile arrives, then drained.
        reset_dut();
        out_ready = 1'b0;
        drive_tile(1'b0);
        idle(15);
        chk("t3 valid held", 32'(out_valid), 32'd1);
        chk("t3 data held", 32'(out_data), 32'd2);
        chk("t3 no overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        idle(9);
        chk("t3 one word per cycle", 32'(got.size()), 32'd9);

        // Overflow on row 0, sticky until reset; 8 words retrievable.
        reset_dut();
        out_ready = 1'b0;
        for (int j = 0; j < 9; j++) begin
            valid_m2 = 3'b001; m2[0] = 16'(100 + j);
            tick();
        end
        idle(1);
        chk("t4 overflow set", 32'(overflow), 32'd1);
        idle(5);
        chk("t4 overflow sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            valid_m2 = 3'b110; m2[1] = 16'(200 + j); m2[2] = 16'(300 + j);
            tick();
        end
        idle(40);
        row0_cnt = 0;
        foreach (got[e]) if (got[e].data < 16'd200) row0_cnt++;
        chk("t4 row0 words retrieved", 32'(row0_cnt), 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4 reset overflow", 32'(overflow), 32'd0);
        chk("t4 reset out_valid", 32'(out_valid), 32'd0);

        // Full FIFO pushed and popped in one cycle.
        reset_dut();
        out_ready = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            valid_m2 = 3'b001; m2[0] = 16'(j + 1);
            tick();
        end
        out_ready = 1'b1; valid_m2 = 3'b001; m2[0] = 16'h0AAA;
        tick();
        out_ready = 1'b0;
        idle(1);
        chk("t5 no overflow", 32'(overflow), 32'd0);
        chk("t5 head advanced", 32'(out_data), 32'd2);
        valid_m2 = 3'b001; m2[0] = 16'h0BBB;
        tick();
        idle(1);
        chk("t5 still full", 32'(overflow), 32'd1);

        // Output clamp vectors.
        reset_dut();
        for (int j = 0; j < 3; j++) begin
            out_ready = 1'b0; valid_m2 = 3'b001; m2[0] = rv[j].din;
            tick();
            valid_m2 = '0;
            chk("t6 relu data", 32'(out_data), 32'(rv[j].dexp));
            out_ready = 1'b1;
            tick();
        end

        // Randomized traffic with a mid-run reset.
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            rst = (c == 200);
            for (int i = 0; i < N; i++) begin
                valid_m2[i] = ($urandom % 4) == 0;
                m2[i] = 16'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
